// File: rtl/csa19_accum.sv
// csa19_accum: valid/ready group accumulator built around a 19-bit carry-select adder.
// Terms are summed until one arrives with i_last. The result is then held until
// the consumer takes it, and one bubble cycle follows before the next group.
// Optional build macro: CSA19_ACCUM_SAT_EN. When defined, the accumulator saturates
// to all ones on carry-out. By default it wraps modulo 2^WIDTH.

// 19-bit carry-select adder: 4-bit ripple low block, then three 5-bit select blocks.
module csa_19bit (
    input  logic [18:0] i_a,
    input  logic [18:0] i_b,
    input  logic        i_cin,
    output logic [18:0] o_sum,
    output logic        o_cout
);

    logic [4:0] lo_r;
    logic [5:0] b1_0, b1_1, b2_0, b2_1, b3_0, b3_1;
    logic       c4, c9, c14;

    // Each upper block precomputes both carry-in cases; the incoming carry selects one.
    always_comb begin
        lo_r = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'd0, i_cin};
        b1_0 = {1'b0, i_a[8:4]}   + {1'b0, i_b[8:4]};
        b1_1 = b1_0 + 6'd1;
        b2_0 = {1'b0, i_a[13:9]}  + {1'b0, i_b[13:9]};
        b2_1 = b2_0 + 6'd1;
        b3_0 = {1'b0, i_a[18:14]} + {1'b0, i_b[18:14]};
        b3_1 = b3_0 + 6'd1;

        c4  = lo_r[4];
        c9  = c4  ? b1_1[5] : b1_0[5];
        c14 = c9  ? b2_1[5] : b2_0[5];

        o_sum[3:0]   = lo_r[3:0];
        o_sum[8:4]   = c4  ? b1_1[4:0] : b1_0[4:0];
        o_sum[13:9]  = c9  ? b2_1[4:0] : b2_0[4:0];
        o_sum[18:14] = c14 ? b3_1[4:0] : b3_0[4:0];
        o_cout       = c14 ? b3_1[5]   : b3_0[5];
    end

endmodule

module csa19_accum #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    logic [18:0]        add_sum;
    logic               add_cout;
    logic               accept_c;

    csa_19bit u_add (
        .i_a    (19'(acc_q)),
        .i_b    (19'(i_data)),
        .i_cin  (1'b0),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    // ready_q already encodes "not in HOLD", so accept never depends on i_valid feedback.
    assign accept_c = i_valid & ready_q;

    // Next-state and datapath update; handshake flags are derived from the next state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE, S_ACC: begin
                if (accept_c) begin
`ifdef CSA19_ACCUM_SAT_EN
                    acc_d = add_cout ? '1 : WIDTH'(add_sum);
`else
                    acc_d = WIDTH'(add_sum);
`endif
                    ovf_d   = ovf_q | add_cout;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = i_last ? S_HOLD : S_ACC;
                end
            end
            S_HOLD: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d != S_HOLD);
        valid_d = (state_d == S_HOLD);
    end

    // State and output registers; reset discards any partial or pending group.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_sum   = acc_q;
    assign o_ovf   = ovf_q;
    assign o_count = cnt_q;

endmodule

// File: tb/tb_csa19_accum.sv
// Testbench for csa19_accum. Group results are predicted from plain integer sums.
// Build macro CSA19_ACCUM_SAT_EN selects the saturating expectation.
module tb_csa19_accum;

    localparam int unsigned WIDTH = 19;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             i_clk;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_ovf;
    logic [CNT_W-1:0] o_count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] terms[$];

    csa19_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_ovf   (o_ovf),
        .o_count (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    // Expected result of the group in 'terms' from the true (unbounded) sum.
    function automatic void model(output logic [WIDTH-1:0] s, output logic ovf,
                                  output logic [CNT_W-1:0] cnt);
        longint unsigned total = 0;
        foreach (terms[i]) total += 64'(terms[i]);
        ovf = (total >= (64'd1 << WIDTH));
`ifdef CSA19_ACCUM_SAT_EN
        s = ovf ? '1 : WIDTH'(total);
`else
        s = WIDTH'(total);
`endif
        cnt = (terms.size() > int'(CMAX)) ? CMAX : CNT_W'(terms.size());
    endfunction

    // Present the queued terms, optionally with idle gaps carrying junk data.
    task automatic send_group(input bit gaps, input bit with_last);
        for (int i = 0; i < terms.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_valid = 1'b0;
                i_data  = WIDTH'($urandom);
                i_last  = 1'b1;
                tick();
            end
            checks++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
                failures++;
                $display("FAIL accept_ready: term %0d ready=%b valid=%b required ready=1 valid=0",
                         i, o_ready, o_valid);
            end
            i_valid = 1'b1;
            i_data  = terms[i];
            i_last  = with_last && (i == terms.size() - 1);
            tick();
        end
        i_valid = 1'b0;
        i_data  = WIDTH'($urandom);
        i_last  = 1'($urandom);
    endtask

    // Check the held result for hold+1 cycles, then release it and check the return to idle.
    task automatic check_result(input int hold, input string tag);
        logic [WIDTH-1:0] es;
        logic             eo;
        logic [CNT_W-1:0] ec;
        model(es, eo, ec);
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_sum !== es ||
                o_ovf !== eo || o_count !== ec) begin
                failures++;
                $display("FAIL %s_hold%0d: valid=%b ready=%b sum=%h ovf=%b cnt=%0d required 1 0 %h %b %0d",
                         tag, h, o_valid, o_ready, o_sum, o_ovf, o_count, es, eo, ec);
            end
            i_ready = (h == hold);
            i_valid = 1'($urandom);
            i_data  = WIDTH'($urandom);
            i_last  = 1'($urandom);
            tick();
        end
        i_ready = 1'b0;
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sum !== '0 ||
            o_ovf !== 1'b0 || o_count !== '0) begin
            failures++;
            $display("FAIL %s_release: valid=%b ready=%b sum=%h ovf=%b cnt=%0d required 0 1 0 0 0",
                     tag, o_valid, o_ready, o_sum, o_ovf, o_count);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b1; i_data = 19'h12345; i_last = 1'b1; i_ready = 1'b0;
        tick(); tick();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_sum !== '0 ||
            o_ovf !== 1'b0 || o_count !== '0) begin
            failures++;
            $display("FAIL reset_values: ready=%b valid=%b sum=%h ovf=%b cnt=%0d required 1 0 0 0 0",
                     o_ready, o_valid, o_sum, o_ovf, o_count);
        end
        // First rising edge after release must accept.
        i_rst = 1'b0;
        terms = '{19'd10};
        send_group(1'b0, 1'b1);
        check_result(0, "first_accept");
    endtask

    task automatic test_basic();
        terms = '{19'd5, 19'd7, 19'd9};
        send_group(1'b0, 1'b1);
        check_result(0, "basic_5_7_9");
    endtask

    task automatic test_hold();
        terms = '{19'h7FFFF};
        send_group(1'b0, 1'b1);
        check_result(4, "hold_stall");
    endtask

    task automatic test_overflow();
        terms = '{19'h7FFFF, 19'h00002};
        send_group(1'b0, 1'b1);
        check_result(1, "overflow");
        terms = '{19'h40000, 19'h40000, 19'h00000, 19'h00003};
        send_group(1'b1, 1'b1);
        check_result(0, "overflow_zero_tail");
    endtask

    task automatic test_count_sat();
        terms = {};
        for (int i = 0; i < 300; i++) terms.push_back(19'd1);
        send_group(1'b0, 1'b1);
        check_result(0, "count_sat");
    endtask

    task automatic test_reset_mid();
        terms = '{WIDTH'($urandom), WIDTH'($urandom)};
        send_group(1'b0, 1'b0);
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_sum !== '0 ||
            o_ovf !== 1'b0 || o_count !== '0) begin
            failures++;
            $display("FAIL reset_mid_acc: ready=%b valid=%b sum=%h ovf=%b cnt=%0d required 1 0 0 0 0",
                     o_ready, o_valid, o_sum, o_ovf, o_count);
        end
        tick();
        i_rst = 1'b0;
        terms = '{19'd4};
        send_group(1'b0, 1'b1);
        check_result(0, "after_mid_reset");
        // Reset while a result is pending drops it.
        terms = '{19'd3};
        send_group(1'b0, 1'b1);
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sum !== '0 || o_count !== '0) begin
            failures++;
            $display("FAIL reset_in_hold: valid=%b ready=%b sum=%h cnt=%0d required 0 1 0 0",
                     o_valid, o_ready, o_sum, o_count);
        end
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_random();
        for (int g = 0; g < 20; g++) begin
            int n;
            n = $urandom_range(1, 6);
            terms = {};
            for (int i = 0; i < n; i++)
                terms.push_back(($urandom_range(0, 1) == 1) ? WIDTH'($urandom)
                                                             : WIDTH'($urandom_range(0, 1000)));
            send_group(1'b1, 1'b1);
            check_result($urandom_range(0, 3), $sformatf("random%0d", g));
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] g[$];
        bit               lst[$];
        logic [WIDTH-1:0] es[2];
        logic             eo[2];
        logic [CNT_W-1:0] ec[2];
        int idx = 0, results = 0, stalls = 0, cyc = 0;

        terms = '{WIDTH'($urandom_range(0, 5000)), WIDTH'($urandom_range(0, 5000)),
                  WIDTH'($urandom_range(0, 5000))};
        model(es[0], eo[0], ec[0]);
        foreach (terms[i]) begin g.push_back(terms[i]); lst.push_back(i == 2); end
        terms = '{WIDTH'($urandom), WIDTH'($urandom)};
        model(es[1], eo[1], ec[1]);
        foreach (terms[i]) begin g.push_back(terms[i]); lst.push_back(i == 1); end

        i_ready = 1'b1;
        while (results < 2 && cyc < 60) begin
            if (o_valid === 1'b1) begin
                checks++;
                if (o_sum !== es[results] || o_ovf !== eo[results] || o_count !== ec[results]) begin
                    failures++;
                    $display("FAIL b2b_group%0d: sum=%h ovf=%b cnt=%0d required %h %b %0d",
                             results, o_sum, o_ovf, o_count, es[results], eo[results], ec[results]);
                end
                results++;
            end
            if (idx < g.size()) begin
                i_valid = 1'b1;
                i_data  = g[idx];
                i_last  = lst[idx];
                if (o_ready === 1'b1) idx++;
                else stalls++;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        checks++;
        if (results != 2) begin
            failures++;
            $display("FAIL b2b_timeout: results=%0d required 2", results);
        end
        checks++;
        if (stalls != 1) begin
            failures++;
            $display("FAIL b2b_bubbles: bubbles=%0d required 1", stalls);
        end
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sum !== '0) begin
            failures++;
            $display("FAIL b2b_idle: valid=%b ready=%b sum=%h required 0 1 0", o_valid, o_ready, o_sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overflow();
        test_count_sat();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
